aes_key_expand: RTL and testbench

- Runtime-selectable AES key schedule (FIPS-197) for AES-128, AES-192 and AES-256 in one instance.
- Key size is chosen per request rather than fixed at compile time.
- Accepts a key over a valid/ready handshake and streams round keys 0..Nr, one 128-bit round key per transfer, over a second valid/ready handshake.
- Feeds the round datapath of the cipher core.

---
 rtl/aes_const.sv | 56 +++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expand.sv | 183 ++++++++++++++++++
 tb/tb_aes_key_expand.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_const.sv
// Shared AES constants for the key schedule.
//   NB          : words per state / round key (always 4)
//   aes_klen_t  : key length selector encoding
//   kx_state_t  : key expander controller states
//   klen_to_nk  : key length code -> key words (4/6/8, code 3 maps to 4)
//   klen_to_nr  : key length code -> rounds (10/12/14)
//   SBOX        : forward S-box table
//   xtime       : multiply by x in GF(2^8), used to step Rcon
package aes_const;

  localparam int NB = 4;

  typedef enum logic [1:0] {AES128 = 2'd0, AES192 = 2'd1, AES256 = 2'd2} aes_klen_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GEN = 2'd1, S_FLUSH = 2'd2} kx_state_t;

  function automatic logic [3:0] klen_to_nk(input logic [1:0] klen);
    case (klen)
      AES192:  klen_to_nk = 4'd6;
      AES256:  klen_to_nk = 4'd8;
      default: klen_to_nk = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] klen_to_nr(input logic [1:0] klen);
    case (klen)
      AES192:  klen_to_nr = 4'd12;
      AES256:  klen_to_nr = 4'd14;
      default: klen_to_nr = 4'd10;
    endcase
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
//   word : input word
//   sub  : S-box substituted word (byte-wise)
import aes_const::*;

module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_expand.sv
// Runtime-selectable AES-128/192/256 key schedule. Accepts a key on a
// valid/ready handshake and streams round keys 0..Nr, one per transfer.
//   clock, reset             : clock, synchronous active-high reset
//   start_valid/start_ready  : key request handshake (ready only in IDLE)
//   key_len                  : 0=128, 1=192, 2=256, 3=128; sampled on accept
//   key                      : left-aligned key, word 0 in the top 32 bits
//   rk_valid/rk_ready        : round key handshake
//   rk_data, rk_idx, rk_last : round key, round number, last-round flag
//   rd_idx, rd_data          : round key store read port
// Optional feature macro AES_KEY_STORE_EN: when defined, every loaded round
// key is also written to a 15-entry store readable with 1-cycle latency;
// otherwise rd_data is tied to 0.
//
// state   | meaning
// S_IDLE  | waiting for a key request
// S_GEN   | producing one schedule word per non-stalled cycle
// S_FLUSH | all words produced, waiting for the last round key transfer
import aes_const::*;

module aes_key_expand #(
  parameter int MAXNK = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [1:0]           key_len,
  input  logic [32*MAXNK-1:0]  key,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [127:0]         rk_data,
  output logic [3:0]           rk_idx,
  output logic                 rk_last,
  input  logic [3:0]           rd_idx,
  output logic [127:0]         rd_data
);

  localparam int AW = $clog2(MAXNK);

  kx_state_t state, state_nxt;
  logic accept, gen_step, load_rk;

  logic [32*MAXNK-1:0] key_reg, key_sh;
  logic [3:0]  nk, nr, nk_req;
  logic [1:0]  eff_klen;
  logic [5:0]  i, i_last;
  logic [2:0]  modc;          // i mod nk, kept as a wrapping counter
  logic [7:0]  rcon;
  logic [1:0]  acnt;          // words currently held in the assembler
  logic [3:0]  rnd;           // round number of the next key to load
  logic [31:0] win [MAXNK];   // win[k] = w[i-1-k]
  logic [31:0] asm0, asm1, asm2;
  logic [31:0] w_prev, w_back, sw_in, sw_out, w_new;
  logic [AW-1:0] back_idx;
  logic [127:0] rk_new;

  aes_sub_word u_sub_word (
    .word (sw_in),
    .sub  (sw_out)
  );

  // Key lengths wider than the key port fall back to AES-128.
  always_comb begin
    nk_req   = klen_to_nk(key_len);
    eff_klen = (nk_req > 4'(MAXNK)) ? AES128 : key_len;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_valid) state_nxt = S_GEN;
      S_GEN:   if (gen_step && (i == i_last)) state_nxt = S_FLUSH;
      S_FLUSH: if (rk_valid && rk_ready && rk_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Generation holds only when the assembler is full and the output
  // register cannot be freed this cycle.
  always_comb begin
    start_ready = (state == S_IDLE);
    accept      = start_ready && start_valid;
    gen_step    = (state == S_GEN) && !((acnt == 2'd3) && rk_valid && !rk_ready);
    load_rk     = gen_step && (acnt == 2'd3);
  end

  always_comb begin
    i_last   = {nr, 2'b11};
    key_sh   = key_reg << {i, 5'd0};
    back_idx = AW'(nk - 4'd1);
    w_prev   = win[0];
    w_back   = win[back_idx];
    sw_in    = (modc == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (i < {2'b00, nk})
      w_new = key_sh[32*MAXNK-1 -: 32];
    else if (modc == 3'd0)
      w_new = w_back ^ sw_out ^ {rcon, 24'h0};
    else if ((nk == 4'd8) && (modc == 3'd4))
      w_new = w_back ^ sw_out;
    else
      w_new = w_back ^ w_prev;
    rk_new = {asm0, asm1, asm2, w_new};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_reg  <= '0;
      nk       <= 4'd4;
      nr       <= 4'd10;
      i        <= '0;
      modc     <= '0;
      rcon     <= 8'h01;
      acnt     <= '0;
      rnd      <= '0;
      asm0     <= '0;
      asm1     <= '0;
      asm2     <= '0;
      for (int k = 0; k < MAXNK; k++) win[k] <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
    end else begin
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      if (accept) begin
        key_reg <= key;
        nk      <= klen_to_nk(eff_klen);
        nr      <= klen_to_nr(eff_klen);
        i       <= '0;
        modc    <= '0;
        rcon    <= 8'h01;
        acnt    <= '0;
        rnd     <= '0;
      end else if (gen_step) begin
        for (int k = MAXNK-1; k > 0; k--) win[k] <= win[k-1];
        win[0] <= w_new;
        i      <= i + 6'd1;
        modc   <= ({1'b0, modc} == nk - 4'd1) ? 3'd0 : modc + 3'd1;
        if ((i >= {2'b00, nk}) && (modc == 3'd0)) rcon <= xtime(rcon);
        case (acnt)
          2'd0: asm0 <= w_new;
          2'd1: asm1 <= w_new;
          2'd2: asm2 <= w_new;
          default: ;
        endcase
        if (load_rk) begin
          rk_data  <= rk_new;
          rk_valid <= 1'b1;
          rk_idx   <= rnd;
          rk_last  <= (rnd == nr);
          rnd      <= rnd + 4'd1;
          acnt     <= '0;
        end else begin
          acnt <= acnt + 2'd1;
        end
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [127:0] store [0:14];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < 15; k++) store[k] <= '0;
      rd_data <= '0;
    end else begin
      if (load_rk) store[rnd] <= rk_new;
      rd_data <= (rd_idx <= 4'd14) ? store[rd_idx] : '0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^rd_idx;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
`timescale 1ns/1ps
module tb_aes_key_expand;

  localparam int MAXNK = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;

  aes_key_expand #(.MAXNK(MAXNK)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_len     (key_len),
    .key         (key),
    .rk_valid    (rk_valid),
    .rk_ready    (rk_ready),
    .rk_data     (rk_data),
    .rk_idx      (rk_idx),
    .rk_last     (rk_last),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_m [256];
  logic [31:0]  w_m    [60];
  logic [127:0] exp_rk [16];
  logic [127:0] got_rk [16];
  int           exp_nr;
  int           exp_next;
  bit           active = 1'b0;
  bit           done = 1'b0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_data;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook FIPS-197 expansion over a flat word array.
  task automatic build_model(input logic [1:0] kl, input logic [255:0] k);
    int nk, nr;
    logic [255:0] t;
    logic [31:0]  tmp;
    logic [7:0]   rc;
    nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    nr = nk + 6;
    for (int n = 0; n < nk; n++) begin
      t = k << (32 * n);
      w_m[n] = t[255:224];
    end
    for (int n = nk; n < 4 * (nr + 1); n++) begin
      tmp = w_m[n-1];
      if (n % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < n / nk; j++) rc = gmul(rc, 8'h02);
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && n % 8 == 4) begin
        tmp = subw(tmp);
      end
      w_m[n] = w_m[n-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) exp_rk[r] = '0;
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
    exp_nr = nr;
  endtask

  // Output checker: every presented round key against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (rk_valid && !active) begin
        check("spurious_valid", 128'(rk_valid), 128'd0);
      end else if (rk_valid) begin
        check("rk_idx", 128'(rk_idx), 128'(exp_next));
        check("rk_data", rk_data, exp_rk[exp_next & 15]);
        check("rk_last", 128'(rk_last), 128'(exp_next == exp_nr));
        if (prev_stall) check("rk_stable", rk_data, prev_data);
        prev_stall = !rk_ready;
        prev_data  = rk_data;
        if (rk_ready) begin
          got_rk[exp_next & 15] = rk_data;
          if (exp_next == exp_nr) done = 1'b1;
          if (exp_next < 15) exp_next++;
        end
      end else if (active) begin
        if (prev_stall) check("valid_held", 128'(rk_valid), 128'd1);
        prev_stall = 1'b0;
      end
      if (active && !done) check("start_ready_busy", 128'(start_ready), 128'd0);
    end
  end

  task automatic start_req(input logic [1:0] kl, input logic [255:0] k);
    int n = 0;
    build_model(kl, k);
    exp_next   = 0;
    done       = 1'b0;
    prev_stall = 1'b0;
    for (int r = 0; r < 16; r++) got_rk[r] = '0;
    key_len     = kl;
    key         = k;
    start_valid = 1'b1;
    while (!start_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    start_valid = 1'b0;
    active      = 1'b1;
  endtask

  // Run until the final round key transfers; lat = edges after accept at
  // which round lat_idx was first seen valid.
  task automatic drain(input bit bp, input int lat_idx, output int lat);
    int n = 0;
    lat = -1;
    rk_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (n < 600) begin
      @(posedge clock); #1;
      n++;
      if (rk_valid && int'(rk_idx) == lat_idx && lat < 0) lat = n;
      if (done) break;
      start_valid = bp && (n < 20);
      rk_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    start_valid = 1'b0;
    check("drain_done", 128'(done), 128'd1);
    if (done) check("start_ready_after_last", 128'(start_ready), 128'd1);
    active   = 1'b0;
    rk_ready = 1'b1;
  endtask

  initial begin
    int lat;
    int n;
    reset       = 1'b1;
    start_valid = 1'b0;
    key_len     = 2'd0;
    key         = '0;
    rk_ready    = 1'b1;
    rd_idx      = 4'd0;
    build_sbox();
    check("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_data", rk_data, 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    check("rst_rk_last", 128'(rk_last), 128'd0);
    check("rst_start_ready", 128'(start_ready), 128'd1);
    check("rst_rd_data", rd_data, 128'd0);

    // AES-128, no backpressure, garbage in the unused key bits
    start_req(2'd0, {K128, 128'hdeadbeef_cafef00d_01234567_89abcdef});
    check("model128_r1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model128_r10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    drain(1'b0, 10, lat);
    check("aes128_r0", got_rk[0], K128);
    check("aes128_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes128_r10_latency", 128'(lat), 128'd44);

    // store read-back
    rd_idx = 4'd10;
    @(posedge clock); #1;
`ifdef AES_KEY_STORE_EN
    check("store_rd10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`else
    check("store_rd10", rd_data, 128'd0);
`endif
    rd_idx = 4'd1;
    @(posedge clock); #1;
`ifdef AES_KEY_STORE_EN
    check("store_rd1", rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
`else
    check("store_rd1", rd_data, 128'd0);
`endif
    rd_idx = 4'd15;
    @(posedge clock); #1;
    check("store_rd15", rd_data, 128'd0);

    // AES-192
    start_req(2'd1, {K192, 64'h5555aaaa_5555aaaa});
    check("model192_r12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    drain(1'b0, 12, lat);
    check("aes192_r12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    check("aes192_r12_latency", 128'(lat), 128'd52);

    // AES-256 with random backpressure; inputs disturbed after accept
    start_req(2'd2, K256);
    key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_len = 2'd0;
    check("model256_r14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    drain(1'b1, 14, lat);
    check("aes256_r0", got_rk[0], K256[255:128]);
    check("aes256_r14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // reset during AES-192 generation at round 5
    start_req(2'd1, {K192, 64'h0});
    n = 0;
    rk_ready = 1'b1;
    while (!(rk_valid && rk_idx == 4'd5) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("reached_r5", 128'(rk_valid && rk_idx == 4'd5), 128'd1);
    active = 1'b0;
    reset  = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_rk_valid", 128'(rk_valid), 128'd0);
    check("abort_rk_idx", 128'(rk_idx), 128'd0);
    check("abort_rk_data", rk_data, 128'd0);
    check("abort_start_ready", 128'(start_ready), 128'd1);
    repeat (6) @(posedge clock);
    #1;

    // AES-128 via key_len=3 after the abort
    start_req(2'd3, {K128, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210});
    drain(1'b0, 10, lat);
    check("post_reset_r0", got_rk[0], K128);
    check("post_reset_r10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("post_reset_latency", 128'(lat), 128'd44);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
